// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and parity selection.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // data_xor is the reduction XOR of the payload; odd parity inverts it.
    function automatic logic parity_sel(input logic data_xor, input logic typ);
        return (typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// Loadable LSB-first shift register with bit counter; done marks all payload bits shifted out.
module uart_tx_shift #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  bit_out,
    output logic                  done
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] sreg;
    logic [CNT_W-1:0]      cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= load_data;
            cnt  <= '0;
        end else if (shift) begin
            sreg <= {1'b0, sreg[DATA_WIDTH-1:1]};
            cnt  <= cnt + CNT_W'(1);
        end
    end

    assign bit_out = sreg[0];
    assign done    = (cnt == CNT_W'(DATA_WIDTH));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame FSM, parity generation and registered serial output.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    uart_state_t state, state_nxt;

    logic tx_nxt;
    logic busy_nxt;
    logic load;
    logic shift;
    logic bit_out;
    logic done;
    logic par_en_q;
    logic par_q;

    uart_tx_shift #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .load_data (p_data),
        .bit_out   (bit_out),
        .done      (done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            tx_out <= tx_nxt;
            busy   <= busy_nxt;
            // Parity is fixed at acceptance so later input changes cannot disturb the frame.
            if (load) begin
                par_en_q <= par_en;
                par_q    <= parity_sel(^p_data, par_typ);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        tx_nxt    = tx_out;
        busy_nxt  = busy;
        load      = 1'b0;
        shift     = 1'b0;

        unique case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (data_valid) begin
                    load      = 1'b1;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt    = bit_out;
                shift     = 1'b1;
                state_nxt = DATA;
            end
            DATA: begin
                if (done) begin
                    if (par_en_q) begin
                        tx_nxt    = par_q;
                        state_nxt = PARITY;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end
                end else begin
                    tx_nxt = bit_out;
                    shift  = 1'b1;
                end
            end
            PARITY: begin
                tx_nxt    = 1'b1;
                state_nxt = STOP;
            end
            STOP: begin
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl with hand-computed serial sequences.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int checks;
    int failures;

    uart_tx_ctrl #(
        .DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // seq[0] is the start bit; samples taken on the falling edge after each rising edge.
    task automatic run_frame(input string name, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [0:11] seq, input int len,
                             input bit now, input int inj_from, input int inj_to);
        if (!now) @(negedge clk);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) begin
                data_valid = 1'b0;
                p_data     = ~d;
                par_en     = ~pe;
                par_typ    = ~pt;
            end
            chk($sformatf("%s_tx[%0d]", name, i), tx_out, seq[i]);
            chk($sformatf("%s_busy[%0d]", name, i), busy, 1'b1);
            if (i == inj_from) begin
                data_valid = 1'b1;
                p_data     = 8'hFF;
            end
            if (i == inj_to) data_valid = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("%s_idle_tx", name), tx_out, 1'b1);
        chk($sformatf("%s_idle_busy", name), busy, 1'b0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        p_data     = 8'h00;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;

        #2 rst = 1'b0;
        #1;
        chk("reset_tx", tx_out, 1'b1);
        chk("reset_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_hold_tx", tx_out, 1'b1);
        rst = 1'b1;

        // 0xA5 even parity: 0 10100101 0 1
        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 12'b010100101010, 11, 1'b0, -1, -1);
        // 0xA5 odd parity: parity slot becomes 1
        run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 12'b010100101110, 11, 1'b0, -1, -1);
        // 0x3C no parity: 0 00111100 1
        run_frame("3c_nopar", 8'h3C, 1'b0, 1'b0, 12'b000111100100, 10, 1'b0, -1, -1);
        // 0x3C with 0xFF request arriving while d3 is on the line
        run_frame("3c_ignore", 8'h3C, 1'b0, 1'b0, 12'b000111100100, 10, 1'b0, 4, 6);

        // Reset while d4 of 0xA5 (even parity) is on the line
        @(negedge clk);
        p_data     = 8'hA5;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            data_valid = 1'b0;
        end
        chk("abort_d4_before", tx_out, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("abort_tx_now", tx_out, 1'b1);
        chk("abort_busy_now", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort_hold_tx[%0d]", i), tx_out, 1'b1);
            chk($sformatf("abort_hold_busy[%0d]", i), busy, 1'b0);
        end
        rst = 1'b1;
        // 0x55 even parity accepted on the first edge after reset release: 0 10101010 0 1
        run_frame("55_after_rst", 8'h55, 1'b1, 1'b0, 12'b010101010010, 11, 1'b1, -1, -1);

        // Back-to-back 0x00 frames: 10-cycle frame plus one idle cycle, period 11
        @(negedge clk);
        p_data     = 8'h00;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        for (int k = 0; k < 33; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_tx[%0d]", k), tx_out, (k % 11) >= 9);
            chk($sformatf("b2b_busy[%0d]", k), busy, (k % 11) != 10);
            if (k == 32) data_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end_tx", tx_out, 1'b1);
        chk("b2b_end_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the number of payload bits per frame.
REQ-002 Port clk, input, 1 bit: bit-rate clock; one serial bit per clk cycle.
REQ-003 Port rst, input, 1 bit: reset, asynchronous, active-low; the block is clocked on clk.
REQ-004 Port p_data, input, DATA_WIDTH bits: parallel payload, sampled only on acceptance.
REQ-005 Port data_valid, input, 1 bit: p_data is valid this cycle.
REQ-006 Port par_en, input, 1 bit: 1 inserts a parity bit, sampled on acceptance.
REQ-007 Port par_typ, input, 1 bit: 0 selects even parity, 1 selects odd parity; sampled on acceptance.
REQ-008 Port tx_out, output, 1 bit: registered serial line, idle high.
REQ-009 Port busy, output, 1 bit: registered; high while a frame is in flight.

Function
REQ-010 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-011 Acceptance SHALL occur on a rising clk edge when state is IDLE (busy=0) and data_valid=1; p_data, par_en and par_typ are latched on that edge.
REQ-012 On the acceptance edge E0, tx_out SHALL be set to 0 (start bit), busy to 1, and state to START.
REQ-013 On edges E1..E(DATA_WIDTH), tx_out SHALL carry the latched data LSB-first (d0..d(N-1)); state is DATA.
REQ-014 If the latched par_en is 1, the next edge SHALL drive the parity bit: XOR of the data for even parity, its inverse for odd parity; state is PARITY.
REQ-015 The next edge SHALL drive the stop bit (tx_out=1); state is STOP.
REQ-016 The edge after STOP SHALL return the FSM to IDLE with tx_out=1 and busy=0.
REQ-017 Frame length SHALL be DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 with parity, plus at least one idle cycle before the next start bit.
REQ-018 data_valid SHALL be ignored while busy=1; there is no queueing of requests.
REQ-019 Changes to p_data, par_en or par_typ mid-frame SHALL NOT affect the frame in flight.
REQ-020 data_valid held high across the idle cycle SHALL start the next frame on that idle edge.
REQ-021 tx_out SHALL be glitch-free: driven from a flop only, never from combinational logic.

Reset
REQ-022 Asserting rst SHALL immediately force tx_out=1, busy=0, state IDLE, the bit counter to 0 and the data latch to 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no further start, data or stop bits.
REQ-024 After deassertion of rst, the first acceptance SHALL be possible on the first clk edge.

Structure
REQ-025 Package uart_pkg SHALL hold the state enumeration and the parity-type constants PAR_EVEN=0 and PAR_ODD=1.
REQ-026 A sub-module uart_tx_shift SHALL implement the loadable LSB-first shift register, the bit counter and a done flag; uart_tx_ctrl SHALL hold the FSM, the parity computation and the output mux.
REQ-027 The bit counter SHALL be $clog2(DATA_WIDTH+1) bits wide and SHALL clear on load.

Verification
REQ-028 p_data=0xA5, par_en=1, par_typ=0 -> tx_out sequence 0,1,0,1,0,0,1,0,1,0,1 (11 cycles); busy high for 11 cycles.
REQ-029 p_data=0xA5, par_en=1, par_typ=1 -> as REQ-028 but with parity bit 1.
REQ-030 p_data=0x3C, par_en=0 -> tx_out 0,0,0,1,1,1,1,0,0,1 (10 cycles) with no parity slot.
REQ-031 Pulse data_valid with 0x3C, then during bit d3 apply data_valid=1 with 0xFF -> 0xFF is ignored and the frame completes as 0x3C.
REQ-032 Assert rst during d4 of 0xA5 -> tx_out=1 and busy=0 immediately; the next accepted 0x55 transmits a complete, correct frame.
REQ-033 Hold data_valid=1 with 0x00 continuously (par_en=0) -> frames repeat with exactly one idle high cycle between each stop bit and the next start bit.
